// File: rtl/icache_pkg.sv
// Shared sizing defaults and FSM encoding for the instruction cache.
package icache_pkg;

   localparam int unsigned ICACHE_INDEX_BITS = 6;
   localparam int unsigned ICACHE_ADDR_BITS  = 18;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StMiss = 1'b1
   } icache_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Tag + data storage for the direct-mapped icache: one write port, one combinational read.
module icache_data_ram #(
   parameter int unsigned IndexBits = 6,
   parameter int unsigned TagBits   = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [IndexBits-1:0] waddr,
   input  logic [TagBits-1:0]   wtag,
   input  logic [31:0]          wdata,
   input  logic [IndexBits-1:0] raddr,
   output logic [TagBits-1:0]   rtag,
   output logic [31:0]          rdata
);

   localparam int unsigned Lines = 1 << IndexBits;

   logic [TagBits+31:0] mem_q [Lines];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= {wtag, wdata};
      end
   end

   assign {rtag, rdata} = mem_q[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int unsigned ADDR_BITS  = ICACHE_ADDR_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_rst,
   input  logic        inv_all,
   input  logic        IF_valid,
   input  logic [31:0] IF_addr,
   output logic        IF_send,
   output logic [31:0] IF_inst,
   output logic        mem_send,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_val
);

   localparam int unsigned TagBits = ADDR_BITS - INDEX_BITS - 2;
   localparam int unsigned Lines   = 1 << INDEX_BITS;

   icache_state_e          state_q, state_d;
   logic [Lines-1:0]       valid_q, valid_d;
   logic                   if_send_q, if_send_d;
   logic [31:0]            if_inst_q, if_inst_d;
   logic                   mem_send_q, mem_send_d;
   logic [31:0]            mem_addr_q, mem_addr_d;
   logic [INDEX_BITS-1:0]  miss_idx_q, miss_idx_d;
   logic [TagBits-1:0]     miss_tag_q, miss_tag_d;

   logic [INDEX_BITS-1:0]  req_idx;
   logic [TagBits-1:0]     req_tag;
   logic [TagBits-1:0]     rd_tag;
   logic [31:0]            rd_data;
   logic                   hit;
   logic                   ram_we;
   logic                   unused_addr;

   assign req_idx     = IF_addr[INDEX_BITS+1:2];
   assign req_tag     = IF_addr[ADDR_BITS-1:INDEX_BITS+2];
   assign unused_addr = ^IF_addr[1:0];

   icache_data_ram #(
      .IndexBits (INDEX_BITS),
      .TagBits   (TagBits)
   ) u_data_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (miss_idx_q),
      .wtag  (miss_tag_q),
      .wdata (mem_val),
      .raddr (req_idx),
      .rtag  (rd_tag),
      .rdata (rd_data)
   );

   assign hit = valid_q[req_idx] && (rd_tag == req_tag);

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      if_send_d  = if_send_q;
      if_inst_d  = if_inst_q;
      mem_send_d = mem_send_q;
      mem_addr_d = mem_addr_q;
      miss_idx_d = miss_idx_q;
      miss_tag_d = miss_tag_q;
      ram_we     = 1'b0;

      if (rdy) begin
         if_send_d = 1'b0;
         // A flush discards any in-flight miss and any coincident request or fill.
         if (jump_rst) begin
            state_d    = StIdle;
            mem_send_d = 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  // A request overlapping our own response is a protocol error; drop it.
                  if (IF_valid && !if_send_q) begin
                     if (hit) begin
                        if_send_d = 1'b1;
                        if_inst_d = rd_data;
                     end else begin
                        mem_send_d = 1'b1;
                        mem_addr_d = word_align(IF_addr);
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        state_d    = StMiss;
                     end
                  end
               end
               StMiss: begin
                  if (mem_valid) begin
                     ram_we              = 1'b1;
                     valid_d[miss_idx_q] = 1'b1;
                     if_send_d           = 1'b1;
                     if_inst_d           = mem_val;
                     mem_send_d          = 1'b0;
                     state_d             = StIdle;
                  end
               end
               default: state_d = StIdle;
            endcase
         end
         if (inv_all) begin
            valid_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         valid_q    <= '0;
         if_send_q  <= 1'b0;
         if_inst_q  <= '0;
         mem_send_q <= 1'b0;
         mem_addr_q <= '0;
         miss_idx_q <= '0;
         miss_tag_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         if_send_q  <= if_send_d;
         if_inst_q  <= if_inst_d;
         mem_send_q <= mem_send_d;
         mem_addr_q <= mem_addr_d;
         miss_idx_q <= miss_idx_d;
         miss_tag_q <= miss_tag_d;
      end
   end

   assign IF_send  = if_send_q;
   assign IF_inst  = if_inst_q;
   assign mem_send = mem_send_q;
   assign mem_addr = mem_addr_q;

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the IF stage and Memctrl's instruction-fetch port.
- A hit returns the instruction word one cycle after the request. A miss forwards a word fetch to Memctrl, then fills the line and responds to IF.
- Honours the ROB's `jump_rst` by aborting any outstanding miss, so wrong-path fetches are never returned.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 one-word lines).
- ADDR_BITS, 18, significant address bits (memory plus I/O window).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  pause: when low, all state and outputs hold.
- jump_rst  in  1  misprediction flush from ROB.
- inv_all  in  1  clears every valid bit (fence.i hook).
- IF_valid  in  1  one-cycle fetch request pulse.
- IF_addr  in  32  fetch PC.
- IF_send  out  1  one-cycle response strobe to IF.
- IF_inst  out  32  instruction word, valid when IF_send=1.
- mem_send  out  1  word-fetch request to Memctrl; held until mem_valid.
- mem_addr  out  32  word address to Memctrl.
- mem_valid  in  1  Memctrl fetch-complete strobe.
- mem_val  in  32  fetched word.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - IF_send=0, IF_inst=0, mem_send=0, mem_addr=0.
  - All valid bits cleared.
  - Tag/data arrays need no reset.
- Address split:
  - index = IF_addr[INDEX_BITS+1:2].
  - tag = IF_addr[ADDR_BITS-1:INDEX_BITS+2].
  - IF_addr[1:0] ignored.
  - Bits at or above ADDR_BITS ignored.
- rdy=0: no state changes, outputs hold, incoming strobes are ignored that cycle.
- States: IDLE, MISS.
- IDLE:
  - IF_valid with hit (valid[index] && tag match): IF_send<=1 and IF_inst<=data[index] next cycle; stay IDLE. Hit latency is 1 cycle.
  - IF_valid with miss: mem_send<=1, mem_addr<={IF_addr[31:2],2'b00}, latch index/tag, go to MISS.
  - IF_send is otherwise 0; every response is a single cycle.
- MISS:
  - mem_send stays 1 and mem_addr stays stable until mem_valid.
  - On mem_valid: write data[index]<=mem_val and tag, set valid; IF_send<=1, IF_inst<=mem_val; mem_send<=0; go to IDLE.
  - Miss latency is 1 cycle after mem_valid.
- IF_valid while in MISS, or in the same cycle IF_send is asserted, is a protocol violation. IF issues at most one outstanding request; the cache ignores any such pulse.
- jump_rst (highest priority, any state):
  - Next cycle: IF_send=0, mem_send=0, state=IDLE.
  - A coincident mem_valid does not fill the array and produces no response.
  - A coincident IF_valid is dropped.
  - Valid bits are unaffected.
- inv_all: clears all valid bits next cycle. If coincident with a fill, the fill's valid set is also cleared.
- Same-cycle fill and lookup cannot occur (single outstanding request). No bypass required.
- Index wrap: addresses differing only above the index bits alias the same line; a new fill overwrites the line (no replacement choice).

Decomposition:
- config.v: add `ICACHE_INDEX_BITS` default and `ICACHE_IDLE`/`ICACHE_MISS` state encodings alongside existing size macros.
- Sub-module icache_data_ram:
  - 2^INDEX_BITS x (tag+32) storage.
  - One write port, one combinational read port.
- Valid bits are kept in icache itself so the async reset and inv_all act on flops.
- Top-level integration: IF's mem port goes to icache; icache's mem port goes to Memctrl's IF_valid/IF_addr/IF_send/IF_inst.

Test Plan:
- Cold miss: after reset, IF_addr=0x0000_0100 → mem_send=1 with mem_addr=0x100 the next cycle. Memctrl returns mem_val=0x0000_0013 four cycles later → IF_send=1, IF_inst=0x13 exactly one cycle after mem_valid; mem_send=0.
- Hit: repeat the 0x100 fetch → IF_send=1 with 0x13 the next cycle; mem_send never asserted.
- Conflict: fetch 0x000 (fill 0xAAAA_AAAA), then 0x100 (index 0, different tag) → miss. Refetch 0x000 → miss again and refill 0xAAAA_AAAA.
- Flush mid-miss: miss on 0x200, assert jump_rst in the same cycle as mem_valid (0xDEAD_BEEF) → no IF_send, mem_send=0, state IDLE. A later fetch of 0x200 misses again.
- Stall and reset: hold rdy=0 for 3 cycles during MISS with mem_valid pulsing → no state change, mem_send stays 1. Drop rst asynchronously mid-MISS → mem_send and IF_send go 0 immediately, all lines invalid.
- Invalidate: fill 0x040, pulse inv_all, fetch 0x040 → miss (mem_send=1).
